// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/control bundle between instruction memory, datapath flags and PC controls.
interface pc_sequencer_if;
  logic [15:0] instruction_pi;
  logic        branch_cond_pi;
  logic        mem_ready_pi;
  logic        resume_pi;
  logic        clk_en_po;
  logic        branch_taken_po;
  logic [5:0]  branch_immediate_po;
  logic        jump_taken_po;
  logic [11:0] jump_immediate_po;
  logic        mem_req_po;
  logic        halted_po;
  logic [1:0]  state_po;
  logic [15:0] retired_count_po;
  modport master (
    output instruction_pi, branch_cond_pi, mem_ready_pi, resume_pi,
    input  clk_en_po, branch_taken_po, branch_immediate_po, jump_taken_po,
           jump_immediate_po, mem_req_po, halted_po, state_po, retired_count_po
  );
  modport slave (
    input  instruction_pi, branch_cond_pi, mem_ready_pi, resume_pi,
    output clk_en_po, branch_taken_po, branch_immediate_po, jump_taken_po,
           jump_immediate_po, mem_req_po, halted_po, state_po, retired_count_po
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: decodes the fetched instruction each cycle and steers PC advance/branch/jump/hold.
module pc_sequencer (
  input logic           clk_pi,
  input logic           reset_pi,
  pc_sequencer_if.slave bus
);
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [3:0] LD_OP   = 4'h8;
  localparam logic [3:0] ST_OP   = 4'h9;
  localparam logic [3:0] BR_OP   = 4'hC;
  localparam logic [3:0] JMP_OP  = 4'hD;
  typedef enum logic [1:0] {START = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, HALTED = 2'd3} state_t;
  state_t      state_q, state_d;
  logic [15:0] count_q;
  logic [3:0]  op;
  logic        clk_en, br, jmp, mem_req, retire, ready;
  assign op    = bus.instruction_pi[15:12];
  assign ready = bus.mem_ready_pi;
  always_comb begin
    state_d = state_q;
    clk_en  = 1'b0;
    br      = 1'b0;
    jmp     = 1'b0;
    mem_req = 1'b0;
    retire  = 1'b0;
    case (state_q)
      START: state_d = RUN;
      RUN: begin
        case (op)
          HALT_OP: begin
            retire  = 1'b1;
            state_d = HALTED;
          end
          LD_OP, ST_OP: begin
            mem_req = 1'b1;
            clk_en  = ready;
            retire  = ready;
            state_d = ready ? RUN : MEM_WAIT;
          end
          BR_OP: begin
            clk_en = 1'b1;
            br     = bus.branch_cond_pi;
            retire = 1'b1;
          end
          JMP_OP: begin
            clk_en = 1'b1;
            jmp    = 1'b1;
            retire = 1'b1;
          end
          default: begin
            clk_en = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        clk_en  = ready;
        retire  = ready;
        state_d = ready ? RUN : MEM_WAIT;
      end
      HALTED: begin
        clk_en  = bus.resume_pi;
        state_d = bus.resume_pi ? RUN : HALTED;
      end
    endcase
  end
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q <= START;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + {15'd0, retire};
    end
  end
  assign bus.clk_en_po           = clk_en & ~reset_pi;
  assign bus.branch_taken_po     = br & ~reset_pi;
  assign bus.jump_taken_po       = jmp & ~reset_pi;
  assign bus.mem_req_po          = mem_req & ~reset_pi;
  assign bus.halted_po           = (state_q == HALTED) & ~reset_pi;
  assign bus.branch_immediate_po = bus.instruction_pi[5:0];
  assign bus.jump_immediate_po   = bus.instruction_pi[11:0];
  assign bus.state_po            = state_q;
  assign bus.retired_count_po    = count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed steps with a scoreboard queue of expected per-cycle outputs.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_sequencer_if bus ();
  pc_sequencer dut (.clk_pi(clk), .reset_pi(rst), .bus(bus));
  typedef struct packed {
    logic        en, br, jp, mq, hl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [5:0]  bimm;
    logic [11:0] jimm;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] exp_cnt = 16'd0;
  int          vectors = 0;
  int          miscompares = 0;
  localparam logic [15:0] NOP = 16'h0123;
  task automatic step(input string tag, input logic [15:0] ins, input logic c, rdy, res, rs,
                      input logic [1:0] st, input logic en, br, jp, mq, hl, ret);
    exp_t e, got;
    bus.instruction_pi = ins;
    bus.branch_cond_pi = c;
    bus.mem_ready_pi   = rdy;
    bus.resume_pi      = res;
    rst                = rs;
    e.en = en; e.br = br; e.jp = jp; e.mq = mq; e.hl = hl; e.st = st;
    e.cnt = exp_cnt; e.bimm = ins[5:0]; e.jimm = ins[11:0];
    sb.push_back(e);
    @(negedge clk);
    got = {bus.clk_en_po, bus.branch_taken_po, bus.jump_taken_po, bus.mem_req_po, bus.halted_po,
           bus.state_po, bus.retired_count_po, bus.branch_immediate_po, bus.jump_immediate_po};
    e = sb.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
    @(posedge clk);
    #1;
    exp_cnt = rs ? 16'd0 : exp_cnt + {15'd0, ret};
  endtask
  initial begin
    bus.instruction_pi = NOP;
    bus.branch_cond_pi = 1'b0;
    bus.mem_ready_pi   = 1'b0;
    bus.resume_pi      = 1'b0;
    @(posedge clk);
    #1;
    //         tag         instr     c  rdy res rs st  en br jp mq hl ret
    step("reset",      NOP,     1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("start",      NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("nop",      NOP,     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    step("br_taken",   16'hC03E, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    step("br_not",     16'hC03E, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    step("jmp",        16'hD010, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    step("nop_rdy",    NOP,     0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    step("ld_req",     16'h8000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step("ld_wait1",   16'h8000, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0, 0);
    step("ld_wait2",   16'h8000, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    step("ld_done",    16'h8000, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0, 1);
    step("st_fast",    16'h9ABC, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    step("halt",       16'hF000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("halted",   16'hF000, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 0);
    step("halted_br",  16'hC03E, 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0);
    step("resume",     16'hF000, 0, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0);
    step("after_res",  NOP,     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    step("ld_req2",    16'h8000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step("rst_memw",   16'h8000, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    step("post_rst",   16'h8000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++)
      step("fill",     NOP,     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    step("at_ffff",    16'hD010, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    step("wrapped",    NOP,     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
